// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and a variable-latency data memory.
interface mem_wb_stage_if #(
  parameter int ADDR_W = 14
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register: issues loads/stores over a req/ack bus,
// stalls upstream while an access is outstanding, and aborts accesses that never complete.
module mem_wb_stage #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RegWrite_i,
  input  logic                 MemtoReg_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic                 Branch_i,
  input  logic [31:0]          ALUResult_i,
  input  logic [31:0]          rdata2_i,
  input  logic [13:0]          addr_jump_i,
  input  logic [4:0]           rd_i,
  mem_wb_stage_if.master       dmem,
  output logic                 stall_o,
  output logic                 PCSrc_o,
  output logic [13:0]          addr_jump_o,
  output logic                 RegWrite_o,
  output logic                 MemtoReg_o,
  output logic [31:0]          ReadData_o,
  output logic [31:0]          ALUResult_o,
  output logic [4:0]           rd_o,
  output logic                 err_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic        memop;
  logic        timeout;

  assign memop       = MemRead_i | MemWrite_i;
  assign timeout     = (state == WAIT) && !dmem.ack && (wait_cnt == 8'(MAX_WAIT - 1));
  assign PCSrc_o     = Branch_i;
  assign addr_jump_o = addr_jump_i;

  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          stall_o    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (dmem.ack || timeout) state_next = IDLE;
        else                     stall_o    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Bus registers and MEM/WB register; a stalled cycle pushes a bubble into write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      dmem.req    <= 1'b0;
      dmem.we     <= 1'b0;
      dmem.addr   <= '0;
      dmem.wdata  <= '0;
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ReadData_o  <= '0;
      ALUResult_o <= '0;
      rd_o        <= '0;
      err_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (memop) begin
            dmem.req    <= 1'b1;
            dmem.we     <= MemWrite_i;
            dmem.addr   <= ALUResult_i[ADDR_W+1:2];
            dmem.wdata  <= rdata2_i;
            wait_cnt    <= '0;
            RegWrite_o  <= 1'b0;
            MemtoReg_o  <= 1'b0;
            ReadData_o  <= '0;
            ALUResult_o <= '0;
            rd_o        <= '0;
          end else begin
            RegWrite_o  <= RegWrite_i;
            MemtoReg_o  <= MemtoReg_i;
            ReadData_o  <= '0;
            ALUResult_o <= ALUResult_i;
            rd_o        <= rd_i;
          end
        end
        WAIT: begin
          if (dmem.ack) begin
            dmem.req    <= 1'b0;
            RegWrite_o  <= RegWrite_i;
            MemtoReg_o  <= MemtoReg_i;
            ReadData_o  <= dmem.we ? 32'h0 : dmem.rdata;
            ALUResult_o <= ALUResult_i;
            rd_o        <= rd_i;
          end else if (timeout) begin
            // An abandoned access must never commit a register write.
            dmem.req    <= 1'b0;
            err_o       <= 1'b1;
            RegWrite_o  <= 1'b0;
            MemtoReg_o  <= MemtoReg_i;
            ReadData_o  <= '0;
            ALUResult_o <= ALUResult_i;
            rd_o        <= rd_i;
          end else begin
            wait_cnt    <= wait_cnt + 8'd1;
            RegWrite_o  <= 1'b0;
            MemtoReg_o  <= 1'b0;
            ReadData_o  <= '0;
            ALUResult_o <= '0;
            rd_o        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage: an instruction-level model predicts every cycle's outputs,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_wb_stage;
  localparam int ADDR_W   = 14;
  localparam int MAX_WAIT = 15;

  typedef struct packed {
    logic        rw, mtr, mr, mw, br;
    logic [31:0] alu, wd;
    logic [13:0] aj;
    logic [4:0]  rd;
  } instr_t;

  typedef struct packed {
    logic        rw, mtr;
    logic [31:0] rdat, alu;
    logic [4:0]  rd;
  } wb_t;

  logic clk = 1'b0;
  logic rst_n;
  logic RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i;
  logic [31:0] ALUResult_i, rdata2_i;
  logic [13:0] addr_jump_i;
  logic [4:0]  rd_i;
  logic stall_o, PCSrc_o, RegWrite_o, MemtoReg_o, err_o;
  logic [13:0] addr_jump_o;
  logic [31:0] ReadData_o, ALUResult_o;
  logic [4:0]  rd_o;

  mem_wb_stage_if #(.ADDR_W(ADDR_W)) dmem_bus ();

  mem_wb_stage #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .Branch_i(Branch_i), .ALUResult_i(ALUResult_i),
    .rdata2_i(rdata2_i), .addr_jump_i(addr_jump_i), .rd_i(rd_i),
    .dmem(dmem_bus),
    .stall_o(stall_o), .PCSrc_o(PCSrc_o), .addr_jump_o(addr_jump_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .ReadData_o(ReadData_o),
    .ALUResult_o(ALUResult_o), .rd_o(rd_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: exp_* is what must be visible this cycle, nxt_* what must appear after the edge.
  wb_t         exp_wb, nxt_wb;
  logic        exp_req, nxt_req, exp_we, nxt_we, exp_err, nxt_err;
  logic [13:0] exp_addr, nxt_addr;
  logic [31:0] exp_wdata, nxt_wdata;
  logic        exp_stall, exp_pcsrc;
  logic [13:0] exp_aj;
  logic        cmp_en = 1'b0;

  int          stall_seen, err_seen, req_seen;
  logic        last_we;
  logic [13:0] last_addr;
  logic [31:0] last_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("stall_o", 32'(stall_o), 32'(exp_stall));
      check("PCSrc_o", 32'(PCSrc_o), 32'(exp_pcsrc));
      check("addr_jump_o", 32'(addr_jump_o), 32'(exp_aj));
      check("dmem_req", 32'(dmem_bus.req), 32'(exp_req));
      if (exp_req) begin
        check("dmem_we", 32'(dmem_bus.we), 32'(exp_we));
        check("dmem_addr", 32'(dmem_bus.addr), 32'(exp_addr));
        check("dmem_wdata", dmem_bus.wdata, exp_wdata);
      end
      check("RegWrite_o", 32'(RegWrite_o), 32'(exp_wb.rw));
      check("MemtoReg_o", 32'(MemtoReg_o), 32'(exp_wb.mtr));
      check("ReadData_o", ReadData_o, exp_wb.rdat);
      check("ALUResult_o", ALUResult_o, exp_wb.alu);
      check("rd_o", 32'(rd_o), 32'(exp_wb.rd));
      check("err_o", 32'(err_o), 32'(exp_err));
      if (stall_o) stall_seen++;
      if (err_o) err_seen++;
      if (dmem_bus.req) begin
        req_seen++;
        last_we    = dmem_bus.we;
        last_addr  = dmem_bus.addr;
        last_wdata = dmem_bus.wdata;
      end
    end
  end

  task automatic clear_counts();
    stall_seen = 0;
    err_seen   = 0;
    req_seen   = 0;
  endtask

  task automatic model_reset();
    exp_wb = '0; nxt_wb = '0;
    exp_req = 1'b0; nxt_req = 1'b0;
    exp_we = 1'b0; nxt_we = 1'b0;
    exp_addr = '0; nxt_addr = '0;
    exp_wdata = '0; nxt_wdata = '0;
    exp_err = 1'b0; nxt_err = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    exp_wb = nxt_wb; exp_req = nxt_req; exp_we = nxt_we;
    exp_addr = nxt_addr; exp_wdata = nxt_wdata; exp_err = nxt_err;
    nxt_err = 1'b0;
  endtask

  task automatic drive(input instr_t in);
    RegWrite_i = in.rw; MemtoReg_i = in.mtr; MemRead_i = in.mr; MemWrite_i = in.mw;
    Branch_i = in.br; ALUResult_i = in.alu; rdata2_i = in.wd;
    addr_jump_i = in.aj; rd_i = in.rd;
    exp_pcsrc = in.br; exp_aj = in.aj;
  endtask

  task applyStimulus(input instr_t in, input int d, input logic spur, input logic [31:0] rdat);
    logic memop;
    int   n;
    memop = in.mr | in.mw;
    drive(in);
    dmem_bus.ack   = spur;
    dmem_bus.rdata = $urandom;
    exp_stall = memop;
    if (!memop) begin
      nxt_wb  = '{in.rw, in.mtr, 32'h0, in.alu, in.rd};
      nxt_req = 1'b0;
      step();
      dmem_bus.ack = 1'b0;
      return;
    end
    nxt_wb    = '0;
    nxt_req   = 1'b1;
    nxt_we    = in.mw;
    nxt_addr  = in.alu[ADDR_W+1:2];
    nxt_wdata = in.wd;
    step();
    n = (d < MAX_WAIT) ? d : MAX_WAIT - 1;
    for (int k = 0; k < n; k++) begin
      dmem_bus.ack   = 1'b0;
      dmem_bus.rdata = $urandom;
      exp_stall      = 1'b1;
      nxt_wb         = '0;
      step();
    end
    exp_stall = 1'b0;
    nxt_req   = 1'b0;
    if (d >= MAX_WAIT) begin
      dmem_bus.ack = 1'b0;
      nxt_wb  = '{1'b0, in.mtr, 32'h0, in.alu, in.rd};
      nxt_err = 1'b1;
    end else begin
      dmem_bus.ack   = 1'b1;
      dmem_bus.rdata = rdat;
      nxt_wb = '{in.rw, in.mtr, (in.mw ? 32'h0 : rdat), in.alu, in.rd};
    end
    step();
    dmem_bus.ack = 1'b0;
  endtask

  function automatic instr_t rand_instr();
    instr_t in;
    int kind;
    in     = '0;
    kind   = $urandom_range(0, 19);
    in.alu = $urandom;
    in.wd  = $urandom;
    in.aj  = 14'($urandom);
    in.rd  = 5'($urandom);
    in.rw  = 1'($urandom);
    in.mtr = 1'($urandom);
    if (kind < 8) ;
    else if (kind < 13) in.mr = 1'b1;
    else if (kind < 17) in.mw = 1'b1;
    else if (kind < 18) begin in.mr = 1'b1; in.mw = 1'b1; end
    else in.br = 1'b1;
    return in;
  endfunction

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    check(name, act, req);
  endtask

  instr_t t;

  initial begin
    rst_n = 1'b0;
    t = '0;
    drive(t);
    dmem_bus.ack = 1'b0;
    dmem_bus.rdata = '0;
    exp_stall = 1'b0;
    model_reset();
    clear_counts();
    #12;
    checkOutput("reset_req", 32'(dmem_bus.req), 32'h0);
    checkOutput("reset_alu", ALUResult_o, 32'h0);
    checkOutput("reset_err", 32'(err_o), 32'h0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // ALU op: one-cycle write-back.
    t = '0; t.rw = 1'b1; t.alu = 32'h0000_1234; t.rd = 5'd7;
    clear_counts();
    applyStimulus(t, 0, 1'b0, 32'h0);
    checkOutput("alu_regwrite", 32'(RegWrite_o), 32'h1);
    checkOutput("alu_result", ALUResult_o, 32'h0000_1234);
    checkOutput("alu_rd", 32'(rd_o), 32'd7);
    checkOutput("alu_readdata", ReadData_o, 32'h0);
    checkOutput("alu_stall_count", 32'(stall_seen), 32'd0);

    // Load with three empty WAIT cycles.
    t = '0; t.rw = 1'b1; t.mtr = 1'b1; t.mr = 1'b1; t.alu = 32'h0000_0010; t.rd = 5'd3;
    clear_counts();
    applyStimulus(t, 3, 1'b0, 32'hDEAD_BEEF);
    checkOutput("load_addr", 32'(last_addr), 32'd4);
    checkOutput("load_stall_count", 32'(stall_seen), 32'd4);
    checkOutput("load_readdata", ReadData_o, 32'hDEAD_BEEF);
    checkOutput("load_memtoreg", 32'(MemtoReg_o), 32'h1);

    // Store acknowledged in the first WAIT cycle.
    t = '0; t.mw = 1'b1; t.wd = 32'hA5A5_A5A5; t.alu = 32'h0000_0100;
    clear_counts();
    applyStimulus(t, 0, 1'b0, 32'h1111_2222);
    checkOutput("store_we", 32'(last_we), 32'h1);
    checkOutput("store_wdata", last_wdata, 32'hA5A5_A5A5);
    checkOutput("store_stall_count", 32'(stall_seen), 32'd1);
    checkOutput("store_regwrite", 32'(RegWrite_o), 32'h0);

    // Load that never completes.
    t = '0; t.rw = 1'b1; t.mr = 1'b1; t.alu = 32'h0000_0040; t.rd = 5'd9;
    clear_counts();
    applyStimulus(t, 100, 1'b0, 32'h0);
    checkOutput("timeout_stall_count", 32'(stall_seen), 32'd15);
    checkOutput("timeout_err", 32'(err_o), 32'h1);
    checkOutput("timeout_readdata", ReadData_o, 32'h0);
    checkOutput("timeout_regwrite", 32'(RegWrite_o), 32'h0);
    t = '0;
    applyStimulus(t, 0, 1'b0, 32'h0);
    checkOutput("timeout_err_pulses", 32'(err_seen), 32'd1);

    // Branch with a spurious ack while idle.
    t = '0; t.br = 1'b1; t.aj = 14'h0040;
    clear_counts();
    applyStimulus(t, 0, 1'b1, 32'h0);
    checkOutput("branch_pcsrc", 32'(PCSrc_o), 32'h1);
    checkOutput("branch_jump", 32'(addr_jump_o), 32'h40);
    checkOutput("branch_req_cycles", 32'(req_seen), 32'd0);
    checkOutput("branch_stall_count", 32'(stall_seen), 32'd0);

    // Randomized mix.
    for (int i = 0; i < 250; i++) begin
      int d;
      t = rand_instr();
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_WAIT, MAX_WAIT + 5)
                                      : $urandom_range(0, 9);
      applyStimulus(t, d, 1'($urandom_range(0, 3) == 0), $urandom);
    end

    // Reset in the middle of an access that would never be acknowledged.
    t = '0; t.rw = 1'b1; t.mr = 1'b1; t.alu = 32'h0000_0080; t.rd = 5'd5;
    drive(t);
    exp_stall = 1'b1;
    nxt_wb = '0; nxt_req = 1'b1; nxt_we = 1'b0; nxt_addr = 14'h20; nxt_wdata = 32'h0;
    step();
    exp_stall = 1'b1;
    step();
    #1;
    cmp_en = 1'b0;
    t = '0;
    drive(t);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_req", 32'(dmem_bus.req), 32'h0);
    checkOutput("midreset_stall", 32'(stall_o), 32'h0);
    checkOutput("midreset_regwrite", 32'(RegWrite_o), 32'h0);
    checkOutput("midreset_rd", 32'(rd_o), 32'h0);
    checkOutput("midreset_addr", 32'(dmem_bus.addr), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    exp_stall = 1'b0;
    exp_pcsrc = 1'b0;
    exp_aj = '0;
    cmp_en = 1'b1;
    clear_counts();
    for (int i = 0; i < 20; i++) begin
      t = rand_instr();
      applyStimulus(t, $urandom_range(0, 4), 1'b0, $urandom);
    end
    checkOutput("postreset_err_pulses", 32'(err_seen), 32'd0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
